// File: rtl/pipe_stage_reg.sv
// Multi-slice pipeline register with per-slice valid, stall/flush priority and optional statistics.
// Define PIPE_STAGE_STATS_EN to implement the stall/flush/bubble counters; otherwise they read as 0.
module pipe_stage_reg #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 1,
  parameter int FLUSH_ZERO = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DEPTH-1:0] stall,
  input  logic [DEPTH-1:0] flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] kill;
  logic [DEPTH-1:0] prev_hold;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [WIDTH-1:0] src_data [DEPTH];

  // hold/kill of slice i is the OR over slice i and every older slice
  always_comb begin
    hold = '0;
    kill = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hold[i]     = |(stall >> i);
      kill[i]     = |(flush >> i);
      src_data[i] = in_data;
    end
    for (int unsigned i = 1; i < DEPTH; i++) begin
      src_data[i] = data_q[i-1];
    end
  end

  assign prev_hold = hold << 1;
  assign src_valid = (valid_q << 1) | DEPTH'(in_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill[i]) begin
          valid_q[i] <= 1'b0;
          if (FLUSH_ZERO != 0) data_q[i] <= '0;
        end else if (!hold[i]) begin
          if (prev_hold[i]) begin
            valid_q[i] <= 1'b0;
            if (FLUSH_ZERO != 0) data_q[i] <= '0;
          end else begin
            valid_q[i] <= src_valid[i];
            data_q[i]  <= src_data[i];
          end
        end
      end
    end
  end

  assign in_ready  = !hold[0];
  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] bubble_q;

  // saturating counters: stop at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q  <= '0;
      flush_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (hold[0] && (stall_q != '1))     stall_q  <= stall_q + CNT_W'(1);
      if ((|flush) && (flush_q != '1))    flush_q  <= flush_q + CNT_W'(1);
      if (!out_valid && (bubble_q != '1)) bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: three parameterisations sharing one clock and reset.
module tb_pipe_stage_reg;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: DEPTH=3, FLUSH_ZERO=1, CNT_W=4
  logic [7:0] a_in_data, a_out_data;
  logic       a_in_valid, a_in_ready, a_out_valid;
  logic [2:0] a_stall, a_flush;
  logic [3:0] a_stall_cnt, a_flush_cnt, a_bubble_cnt;

  // DUT B: DEPTH=2, FLUSH_ZERO=1
  logic [7:0] b_in_data, b_out_data;
  logic       b_in_valid, b_in_ready, b_out_valid;
  logic [1:0] b_stall, b_flush;
  logic [3:0] b_stall_cnt, b_flush_cnt, b_bubble_cnt;

  // DUT C: DEPTH=1, FLUSH_ZERO=0
  logic [7:0] c_in_data, c_out_data;
  logic       c_in_valid, c_in_ready, c_out_valid;
  logic [0:0] c_stall, c_flush;
  logic [3:0] c_stall_cnt, c_flush_cnt, c_bubble_cnt;

  pipe_stage_reg #(.WIDTH(8), .DEPTH(3), .FLUSH_ZERO(1), .CNT_W(4)) u_a (
    .clk(clk), .reset_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .stall(a_stall), .flush(a_flush), .out_data(a_out_data),
    .out_valid(a_out_valid), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt),
    .bubble_cnt(a_bubble_cnt)
  );

  pipe_stage_reg #(.WIDTH(8), .DEPTH(2), .FLUSH_ZERO(1), .CNT_W(4)) u_b (
    .clk(clk), .reset_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .stall(b_stall), .flush(b_flush), .out_data(b_out_data),
    .out_valid(b_out_valid), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt),
    .bubble_cnt(b_bubble_cnt)
  );

  pipe_stage_reg #(.WIDTH(8), .DEPTH(1), .FLUSH_ZERO(0), .CNT_W(4)) u_c (
    .clk(clk), .reset_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .stall(c_stall), .flush(c_flush), .out_data(c_out_data),
    .out_valid(c_out_valid), .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt),
    .bubble_cnt(c_bubble_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int v);
`ifdef PIPE_STAGE_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // scoreboards: push on accepted input, pop when the output slice is about to move on
  logic       sb_a_en, sb_b_en;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         b_pops;

  always @(negedge clk) begin
    if (sb_a_en) begin
      if (a_out_valid && !a_stall[2]) begin
        if (qa.size() == 0) check("a_sb_underflow", 1, 0);
        else check("a_sb_data", {24'h0, a_out_data}, {24'h0, qa.pop_front()});
      end
      if (a_in_valid && a_in_ready && (a_flush == '0)) qa.push_back(a_in_data);
    end
    if (sb_b_en) begin
      if (b_out_valid && !b_stall[1]) begin
        b_pops++;
        if (qb.size() == 0) check("b_sb_underflow", 1, 0);
        else check("b_sb_data", {24'h0, b_out_data}, {24'h0, qb.pop_front()});
      end
      if (b_in_valid && b_in_ready && (b_flush == '0)) qb.push_back(b_in_data);
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       s;
    logic       f;
    logic [7:0] ed;
    logic       ev;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sd [7];
    logic       sv [7];
    int         idx;

    tbl[0] = '{8'hCD, 1'b1, 1'b0, 1'b0, 8'hCD, 1'b1};
    tbl[1] = '{8'hAB, 1'b1, 1'b0, 1'b1, 8'hCD, 1'b0};
    tbl[2] = '{8'h12, 1'b1, 1'b1, 1'b0, 8'hCD, 1'b0};
    tbl[3] = '{8'h34, 1'b1, 1'b0, 1'b0, 8'h34, 1'b1};
    tbl[4] = '{8'h56, 1'b0, 1'b0, 1'b0, 8'h56, 1'b0};
    tbl[5] = '{8'h78, 1'b1, 1'b1, 1'b1, 8'h56, 1'b0};
    tbl[6] = '{8'h9A, 1'b1, 1'b1, 1'b0, 8'h56, 1'b0};
    tbl[7] = '{8'hBC, 1'b1, 1'b0, 1'b0, 8'hBC, 1'b1};
    tbl[8] = '{8'hDE, 1'b1, 1'b1, 1'b0, 8'hBC, 1'b1};
    tbl[9] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'hBC, 1'b0};

    sd = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    sv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    checks = 0; errors = 0; sb_a_en = 0; sb_b_en = 0; b_pops = 0;

    // reset with random inputs, checked before any clock edge
    rst_n = 1'b0;
    a_in_data = 8'($urandom); a_in_valid = 1'($urandom); a_stall = 3'($urandom); a_flush = 3'($urandom);
    b_in_data = 8'($urandom); b_in_valid = 1'($urandom); b_stall = 2'($urandom); b_flush = 2'($urandom);
    c_in_data = 8'($urandom); c_in_valid = 1'($urandom); c_stall = 1'($urandom); c_flush = 1'($urandom);
    #2;
    check("rst_a_out_valid", {31'h0, a_out_valid}, 0);
    check("rst_a_out_data", {24'h0, a_out_data}, 0);
    check("rst_a_stall_cnt", {28'h0, a_stall_cnt}, 0);
    check("rst_a_flush_cnt", {28'h0, a_flush_cnt}, 0);
    check("rst_a_bubble_cnt", {28'h0, a_bubble_cnt}, 0);
    check("rst_a_in_ready", {31'h0, a_in_ready}, {31'h0, !(|a_stall)});
    a_stall = ~a_stall;
    #1;
    check("rst_a_in_ready_follow", {31'h0, a_in_ready}, {31'h0, !(|a_stall)});
    check("rst_b_out_valid", {31'h0, b_out_valid}, 0);
    check("rst_c_out_valid", {31'h0, c_out_valid}, 0);

    a_in_data = '0; a_in_valid = 0; a_stall = '0; a_flush = '0;
    b_in_data = '0; b_in_valid = 0; b_stall = '0; b_flush = '0;
    c_in_data = '0; c_in_valid = 0; c_stall = '0; c_flush = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check("a_bubble_cnt_2", {28'h0, a_bubble_cnt}, stat(2));

    // streaming on A: 3-edge latency, back-to-back
    sb_a_en = 1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin a_in_valid = 1; a_in_data = 8'h11 * 8'(k + 1); end
      else begin a_in_valid = 0; a_in_data = '0; end
      @(negedge clk);
      if (k > 0) check("a_stream_valid", {31'h0, a_out_valid}, {31'h0, sv[k]});
      if (k >= 3) check("a_stream_data", {24'h0, a_out_data}, {24'h0, sd[k]});
    end
    sb_a_en = 0;
    check("a_sb_empty", qa.size(), 0);

    // stall statistics on A
    @(posedge clk); #1; a_stall = 3'b001;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 3) check("a_stall_cnt_3", {28'h0, a_stall_cnt}, stat(3));
      if (k == 10) check("a_in_ready_stalled", {31'h0, a_in_ready}, 0);
    end
    check("a_stall_cnt_sat", {28'h0, a_stall_cnt}, stat(15));
    a_stall = '0; a_flush = 3'b100;
    @(posedge clk); @(posedge clk); #1;
    a_flush = '0;
    check("a_flush_cnt_2", {28'h0, a_flush_cnt}, stat(2));
    check("a_bubble_cnt_sat", {28'h0, a_bubble_cnt}, stat(15));

    // bubble on B: stall[0] for two cycles while streaming six items
    sb_b_en = 1; idx = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (b_in_valid && b_in_ready) idx++;
      b_stall    = (c == 3 || c == 4) ? 2'b01 : 2'b00;
      b_in_valid = (idx < 6);
      b_in_data  = 8'hB0 + 8'(idx);
      @(negedge clk);
      if (c == 3 || c == 4) check("b_in_ready_stall", {31'h0, b_in_ready}, 0);
      if (c == 4 || c == 5) check("b_bubble_valid", {31'h0, b_out_valid}, 0);
    end
    sb_b_en = 0;
    check("b_sb_empty", qb.size(), 0);
    check("b_sb_pops", b_pops, 6);

    // flush beats stall on overlapping slices (B)
    @(posedge clk); #1; b_in_valid = 1; b_in_data = 8'hA1;
    @(posedge clk); #1; b_in_data = 8'hA2;
    @(posedge clk); #1; b_in_data = 8'hA3; b_stall = 2'b11; b_flush = 2'b01;
    @(negedge clk);
    check("b_pre_flush_data", {24'h0, b_out_data}, 32'hA1);
    check("b_flush_in_ready", {31'h0, b_in_ready}, 0);
    @(posedge clk); #1; b_stall = '0; b_flush = '0; b_in_valid = 0; b_in_data = '0;
    check("b_held_valid", {31'h0, b_out_valid}, 1);
    check("b_held_data", {24'h0, b_out_data}, 32'hA1);
    @(posedge clk); #1;
    check("b_killed_valid", {31'h0, b_out_valid}, 0);
    check("b_killed_data", {24'h0, b_out_data}, 0);

    // table-driven single-slice vectors on C (payload kept on flush)
    @(posedge clk); #1;
    for (int r = 0; r < 10; r++) begin
      c_in_data = tbl[r].d; c_in_valid = tbl[r].v; c_stall = tbl[r].s; c_flush = tbl[r].f;
      @(negedge clk);
      check("c_in_ready", {31'h0, c_in_ready}, {31'h0, !tbl[r].s});
      @(posedge clk); #1;
      check("c_out_data", {24'h0, c_out_data}, {24'h0, tbl[r].ed});
      check("c_out_valid", {31'h0, c_out_valid}, {31'h0, tbl[r].ev});
    end
    c_in_valid = 0; c_stall = '0; c_flush = '0;

    // reset in the middle of a stall on A, then a normal first cycle
    a_in_valid = 1; a_in_data = 8'h77;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    check("a_pre_rst_data", {24'h0, a_out_data}, 32'h77);
    a_stall = 3'b111;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("a_mid_rst_valid", {31'h0, a_out_valid}, 0);
    check("a_mid_rst_data", {24'h0, a_out_data}, 0);
    check("a_mid_rst_stall_cnt", {28'h0, a_stall_cnt}, 0);
    a_stall = '0; a_in_data = 8'h5A;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("a_post_rst_empty", {31'h0, a_out_valid}, 0);
    @(posedge clk); #1;
    check("a_post_rst_valid", {31'h0, a_out_valid}, 1);
    check("a_post_rst_data", {24'h0, a_out_data}, 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
